// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: packs header-counted bundles and writes them.
// Optional trailing checksum byte when IMEM_LOADER_CSUM_EN is defined.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data0,
    output logic [31:0]       mem_data1,
    output logic              core_run,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_HI, S_HDR_LO, S_PAYLOAD, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

`ifdef IMEM_LOADER_CSUM_EN
    localparam state_t S_AFTER = S_CSUM;
`else
    localparam state_t S_AFTER = S_DONE;
`endif

    localparam logic [16:0]     CAP     = 17'(1) << ADDR_W;
    localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state, state_nx;
    logic [7:0]      n_hi;
    logic [7:0]      csum;
    logic [2:0]      cnt;
    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] n_cnt;
    logic [55:0]     asm_q;
    logic            xfer;
    logic [15:0]     hdr;
    logic            last;

    assign xfer = in_valid & in_ready;
    assign hdr  = {n_hi, in_data};
    assign last = (idx + IDX_ONE) == n_cnt;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_nx = S_HDR_HI;
            S_HDR_HI: if (xfer) state_nx = S_HDR_LO;
            S_HDR_LO: begin
                if (xfer) begin
                    if (hdr == 16'd0)
                        state_nx = S_AFTER;
                    else if ({1'b0, hdr} > CAP)
                        state_nx = S_ERR;
                    else
                        state_nx = S_PAYLOAD;
                end
            end
            S_PAYLOAD: if (xfer && cnt == 3'd7) state_nx = S_WRITE;
            S_WRITE: state_nx = last ? S_AFTER : S_PAYLOAD;
            S_CSUM: if (xfer) state_nx = (in_data == csum) ? S_DONE : S_ERR;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are derived from the next state so every flag is registered yet current.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_data0 <= '0;
            mem_data1 <= '0;
            core_run  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            n_hi      <= '0;
            csum      <= '0;
            cnt       <= '0;
            idx       <= '0;
            n_cnt     <= '0;
            asm_q     <= '0;
        end else begin
            state    <= state_nx;
            in_ready <= state_nx inside {S_HDR_HI, S_HDR_LO, S_PAYLOAD, S_CSUM};
            busy     <= state_nx inside {S_HDR_HI, S_HDR_LO, S_PAYLOAD, S_WRITE, S_CSUM};
            done     <= state_nx == S_DONE;
            core_run <= state_nx == S_DONE;
            err      <= state_nx == S_ERR;
            mem_we   <= state_nx == S_WRITE;

            if (state_nx == S_HDR_HI && state != S_HDR_HI) begin
                idx  <= '0;
                cnt  <= '0;
                csum <= '0;
            end

            if (xfer) begin
                case (state)
                    S_HDR_HI: n_hi  <= in_data;
                    S_HDR_LO: n_cnt <= hdr[ADDR_W:0];
                    S_PAYLOAD: begin
                        cnt   <= cnt + 3'd1;
                        csum  <= csum ^ in_data;
                        asm_q <= {in_data, asm_q[55:8]};
                        // Eighth byte completes the bundle straight from the input lane.
                        if (cnt == 3'd7) begin
                            mem_addr  <= idx[ADDR_W-1:0];
                            mem_data0 <= asm_q[31:0];
                            mem_data1 <= {in_data, asm_q[55:32]};
                        end
                    end
                    default: ;
                endcase
            end

            if (state == S_WRITE)
                idx <= idx + IDX_ONE;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a bundle-level stream/write model.
module tb_imem_loader;
    localparam int ADDR_W = 8;
`ifdef IMEM_LOADER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef logic [63:0] bq_t[$];
    typedef logic [7:0]  sq_t[$];

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data0;
    logic [31:0]       mem_data1;
    logic              core_run;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data0(mem_data0),
        .mem_data1(mem_data1), .core_run(core_run), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    int          wr_addr[$];
    logic [63:0] wr_data[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(int'(mem_addr));
            wr_data.push_back({mem_data1, mem_data0});
            check("ready_low_on_write", in_ready, 0);
        end
    end

    function automatic bq_t mk_seq(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) begin
            logic [63:0] v;
            for (int j = 0; j < 8; j++) v[8*j +: 8] = 8'(8*i + j);
            q.push_back(v);
        end
        return q;
    endfunction

    function automatic bq_t mk_rand(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back({$urandom, $urandom});
        return q;
    endfunction

    // mode 0: valid every cycle, 1: valid every other cycle, 2: random valid and stray starts
    task automatic feed(input sq_t s, input int mode);
        int guard = 0;
        bit take;
        @(negedge clk);
        start = 1'b1;
        while (s.size() > 0 && guard < 20000) begin
            case (mode)
                0: in_valid = 1'b1;
                1: in_valid = (guard % 2) == 0;
                default: in_valid = $urandom_range(99) < 60;
            endcase
            in_data = s[0];
            take = in_valid && in_ready;
            @(negedge clk);
            start = (mode == 2) && ($urandom_range(15) == 0);
            if (take) void'(s.pop_front());
            guard++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        check("stream_consumed", s.size(), 0);
    endtask

    task automatic run_case(input string tag, input bq_t b, input int n, input int mode,
                            input bit bad_csum);
        sq_t         s;
        logic [7:0]  x = '0;
        logic [15:0] n16 = n[15:0];
        bit          fits;
        bit          ok;
        int          exp_wr;
        s.push_back(n16[15:8]);
        s.push_back(n16[7:0]);
        fits = n <= (1 << ADDR_W);
        ok = fits;
        if (fits) begin
            for (int i = 0; i < n; i++)
                for (int j = 0; j < 8; j++) begin
                    s.push_back(b[i][8*j +: 8]);
                    x ^= b[i][8*j +: 8];
                end
        end
        if (fits && CSUM_EN) begin
            s.push_back(bad_csum ? (x ^ 8'h5A) : x);
            ok = !bad_csum;
        end
        wr_addr.delete();
        wr_data.delete();
        feed(s, mode);
        if (n == 0 && !CSUM_EN) check({tag, "_done_next_cycle"}, done, 1);
        if (fits && n > 0 && !CSUM_EN) check({tag, "_we_latency"}, mem_we, 1);
        for (int i = 0; i < 30 && !(done || err); i++) @(negedge clk);
        check({tag, "_done"}, done, ok);
        check({tag, "_err"}, err, !ok);
        check({tag, "_core_run"}, core_run, ok);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        exp_wr = fits ? n : 0;
        check({tag, "_nwrites"}, wr_addr.size(), exp_wr);
        for (int i = 0; i < exp_wr && i < wr_addr.size(); i++) begin
            check({tag, "_addr"}, wr_addr[i], i);
            check({tag, "_data"}, wr_data[i], b[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_data0"}, mem_data0, 0);
        check({tag, "_mem_data1"}, mem_data1, 0);
        check({tag, "_core_run"}, core_run, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        bq_t b;
        sq_t part;
        int  n;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        b = mk_seq(2);
        check("t1_model_w0", b[0], 64'h07060504_03020100);
        run_case("t1", b, 2, 0, 1'b0);

        b.delete();
        run_case("t2", b, 0, 0, 1'b0);

        run_case("t3", b, 257, 0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t3_restart_err", err, 0);
        check("t3_restart_ready", in_ready, 1);
        check("t3_restart_core_run", core_run, 0);

        b = mk_seq(2);
        run_case("t4", b, 2, 1, 1'b0);

        part = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h02};
        wr_addr.delete();
        wr_data.delete();
        feed(part, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("t5_reset");
        rst_n = 1'b1;
        check("t5_nwrites", wr_addr.size(), 0);
        run_case("t5_reload", b, 2, 0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(9, 1);
            run_case("rnd", mk_rand(n), n, 2, 1'b0);
        end

        run_case("full", mk_rand(1 << ADDR_W), 1 << ADDR_W, 0, 1'b0);

        b.delete();
        n = $urandom_range(65535, 258);
        run_case("big_err", b, n, 2, 1'b0);

`ifdef IMEM_LOADER_CSUM_EN
        run_case("t6_good", mk_seq(2), 2, 0, 1'b0);
        run_case("t6_bad", mk_seq(2), 2, 0, 1'b1);
        b.delete();
        run_case("t6_zero", b, 0, 0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
